// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the data-phase state type used by the
// response multiplexer and its built-in default slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Who owns the current data phase.
  typedef enum logic [1:0] {
    D_NONE = 2'd0,
    D_SLV  = 2'd1,
    D_ERR1 = 2'd2,
    D_ERR2 = 2'd3
  } dphase_e;

  // NONSEQ/SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bundle of decoder/slave/master signals around the response mux.
// The 'slave' modport is the mux's own view (it sits on the slave side of
// the master); 'master' is the view of whatever drives the address phase
// and the slave responses.
interface ahb_resp_mux_if #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  logic [1:0]                htrans;
  logic [SEL_W-1:0]          hsel_idx;
  logic                      hsel_valid;
  logic [NUM_SLV*DATA_W-1:0] hrdata_bus;
  logic [NUM_SLV-1:0]        hreadyout_bus;
  logic [NUM_SLV-1:0]        hresp_bus;
  logic [DATA_W-1:0]         hrdata;
  logic                      hready;
  logic                      hresp;

  modport slave (
    input  htrans, hsel_idx, hsel_valid, hrdata_bus, hreadyout_bus, hresp_bus,
    output hrdata, hready, hresp
  );

  modport master (
    output htrans, hsel_idx, hsel_valid, hrdata_bus, hreadyout_bus, hresp_bus,
    input  hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped active transfers with the
// two-cycle ERROR response and idle/unmapped-IDLE phases with OKAY.
// Purely combinational on the mux's data-phase state; it decides where
// an unmapped transfer goes next and what the default response looks like.
module ahb_default_slave import ahb_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  dphase_e           state,
  input  logic              active,
  output logic              hready,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output dphase_e           nxt
);

  // Default response for the current data phase.
  always_comb begin
    hrdata = '0;
    hready = (state != D_ERR1);
    hresp  = ((state == D_ERR1) || (state == D_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // ERR1 must always be followed by ERR2; otherwise an unmapped active
  // transfer starts a new error and anything else gets no data phase.
  always_comb begin
    nxt = D_NONE;
    if (state == D_ERR1) nxt = D_ERR2;
    else if (active)     nxt = D_ERR1;
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response mux. The decoder select is captured
// in the address phase (only when HREADY is high) and used in the data
// phase to route the addressed slave's response back to the master.
// Outputs depend only on registered state and slave inputs, never on
// the address-phase inputs.
module ahb_resp_mux import ahb_pkg::*; #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32
) (
  input logic           hclk,
  input logic           hresetn,
  ahb_resp_mux_if.slave bus
);

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  dphase_e           state;
  dphase_e           state_nxt;
  logic [SEL_W-1:0]  dsel;

  logic              hit;
  logic              active;
  logic              hready_mux;
  logic              hresp_mux;
  logic [DATA_W-1:0] hrdata_mux;

  logic              def_hready;
  logic              def_hresp;
  logic [DATA_W-1:0] def_hrdata;
  dphase_e           def_nxt;

  assign active = is_active(bus.htrans);

  // Decoder hit; an index past the last slave (non-power-of-2 NUM_SLV)
  // is unmapped even with hsel_valid set.
  always_comb hit = bus.hsel_valid && (int'(bus.hsel_idx) < NUM_SLV);

  ahb_default_slave #(.DATA_W(DATA_W)) u_dflt (
    .state  (state),
    .active (active),
    .hready (def_hready),
    .hresp  (def_hresp),
    .hrdata (def_hrdata),
    .nxt    (def_nxt)
  );

  // Response routing: the selected slave in D_SLV, the default slave otherwise.
  always_comb begin
    hready_mux = def_hready;
    hresp_mux  = def_hresp;
    hrdata_mux = def_hrdata;
    if (state == D_SLV) begin
      hready_mux = bus.hreadyout_bus[dsel];
      hresp_mux  = bus.hresp_bus[dsel];
      hrdata_mux = bus.hrdata_bus[int'(dsel)*DATA_W +: DATA_W];
    end
  end

  assign bus.hready = hready_mux;
  assign bus.hresp  = hresp_mux;
  assign bus.hrdata = hrdata_mux;

  // Next data phase: capture on HREADY, otherwise hold, except that ERR1
  // advances regardless (its own HREADY is low by construction).
  always_comb begin
    state_nxt = state;
    if (hready_mux)            state_nxt = hit ? D_SLV : def_nxt;
    else if (state == D_ERR1)  state_nxt = def_nxt;
  end

  // Data-phase state and select registers; dsel only moves on a slave capture.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= D_NONE;
      dsel  <= '0;
    end else begin
      state <= state_nxt;
      if (hready_mux && hit) dsel <= bus.hsel_idx;
    end
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
Parametrised AHB-Lite slave-to-master response multiplexer for NUM_SLV slaves. It registers the decoder select during the address phase and routes HRDATA/HREADYOUT/HRESP from the addressed slave during the data phase. It includes a built-in default slave that returns the two-cycle ERROR response for active transfers to unmapped addresses. It sits between the address decoder and the master, and it drives the system HREADY.

Parameters:
NUM_SLV, 4, number of slave ports (2..16)
DATA_W, 32, read data width (32 or 64)
SEL_W, $clog2(NUM_SLV), decoder select width (derived, not overridden)

Ports:
hclk  in  1  system clock
hresetn  in  1  synchronous active-low reset
htrans  in  2  master transfer type, address phase
hsel_idx  in  SEL_W  decoder slave index, address phase
hsel_valid  in  1  decoder hit: address maps to a slave
hrdata_bus  in  NUM_SLV*DATA_W  slave read data; slave i at [i*DATA_W +: DATA_W]
hreadyout_bus  in  NUM_SLV  slave HREADYOUT, bit i = slave i
hresp_bus  in  NUM_SLV  slave HRESP, bit i = slave i
hrdata  out  DATA_W  read data to master
hready  out  1  system HREADY, to master and all slaves
hresp  out  1  response to master (0 OKAY, 1 ERROR)

Behaviour:
- Single clock hclk. Reset is synchronous, active-low on hresetn, and sampled on the rising edge.
- Data-phase FSM states: D_NONE, D_SLV, D_ERR1, D_ERR2. Registers: state and dsel (SEL_W).
- Reset: state=D_NONE, dsel=0. Outputs in D_NONE: hready=1, hresp=0, hrdata=0.
- The address phase is captured only on an edge where hready=1. Next state at capture:
  - hsel_valid=1 and hsel_idx<NUM_SLV -> D_SLV, dsel<=hsel_idx. This holds for any htrans; the slave handles IDLE/BUSY.
  - otherwise, htrans[1]=1 (NONSEQ/SEQ) -> D_ERR1.
  - otherwise -> D_NONE.
- When hready=0, state and dsel hold. The exception is D_ERR1, which always advances to D_ERR2 on the next edge.
- D_SLV outputs: combinational pass-through of slave dsel. hrdata=hrdata_bus[dsel], hready=hreadyout_bus[dsel], hresp=hresp_bus[dsel]. Zero added latency.
- D_ERR1 outputs: hready=0, hresp=1, hrdata=0.
- D_ERR2 outputs: hready=1, hresp=1, hrdata=0. The address phase is captured normally at the end of this cycle, which permits back-to-back errors.
- hsel_idx >= NUM_SLV (non-power-of-2 NUM_SLV) is treated as unmapped even when hsel_valid=1.
- Slave wait states: the FSM stays in D_SLV, and dsel is frozen until the slave drives hreadyout=1.
- Slave two-cycle ERROR is passed through unchanged. The mux does not interpret slave hresp.
- Reset mid-transfer: the next edge with hresetn=0 forces D_NONE, and the outputs return to the reset values in the following cycle. Any pending slave data phase is abandoned.
- Outputs are combinational from state/dsel and the slave inputs only. There is no combinational path from htrans, hsel_idx or hsel_valid to any output.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/HRESP_ERROR constants
  - the dphase_e enum {D_NONE, D_SLV, D_ERR1, D_ERR2}
- Natural sub-module: ahb_default_slave. It holds the ERR1/ERR2 sequencing and produces the default hready/hresp/hrdata. It is instantiated once, and its outputs are selected when state is not D_SLV.

Test Plan:
- Reset: hresetn=0 for 2 cycles, random slave inputs -> hready=1, hresp=0, hrdata=0 every cycle.
- Zero-wait read: NONSEQ, hsel_idx=2, hsel_valid=1; next cycle slave2 drives hrdata=32'hA5A5_0002, hreadyout=1 -> hrdata=32'hA5A5_0002, hready=1, hresp=0. Slave1 data is never visible.
- Wait states: slave3 holds hreadyout=0 for 3 cycles while the decoder changes to idx 0 -> hready=0 for 3 cycles, output stays on slave3 throughout, capture of idx 0 happens only on the edge where hready=1.
- Unmapped NONSEQ (hsel_valid=0) -> next cycle hready=0/hresp=1, then hready=1/hresp=1. A following NONSEQ to slave0 is captured at the end of ERR2 and its data phase is OKAY.
- Unmapped IDLE, and NUM_SLV=3 with hsel_idx=3 NONSEQ -> IDLE gives a single OKAY cycle (hready=1, hresp=0); idx 3 gives the two-cycle ERROR.
- Reset during slave wait: slave1 stalled with hreadyout=0, hresetn=0 for 1 cycle -> hready=1, hresp=0, hrdata=0 on the cycle after the reset edge.
